// File: rtl/fwd_mux_reg.sv
// fwd_mux_reg: registered N:1 forwarding mux with stall / flush control.
//   - Channel k of in_data lives at bits [k*DATA_W +: DATA_W].
//   - An out-of-range select picks channel 0. When such a select is captured
//     with in_valid=1, sel_err pulses for one cycle.
//   - Priority at each rising edge: flush, then stall, then capture.
//   - Optional feature macro: FWD_MUX_STATS_EN. When it is defined, fwd_cnt
//     counts captures with in_valid=1 and sel != 0, saturating at 16'hFFFF.
//     When it is not defined, fwd_cnt is tied to zero.
//   - Every output comes straight from a flop, so no input reaches an output
//     combinationally.
//   - Handshake: in_valid qualifies the selected channel in the current cycle,
//     and out_valid qualifies out_data. There is no ready/backpressure signal.
//     stall holds the output register, and flush inserts a bubble.
module fwd_mux_reg #(
  parameter  int DATA_W = 64,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     sel_err,
  output logic [15:0]              fwd_cnt
);

  logic [DATA_W-1:0] mux_data;
  logic              sel_oob;
  logic              capture;

  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              sel_err_q,   sel_err_d;

  // Select a channel. Any select value that matches no channel falls back to
  // channel 0 and is flagged as out of range.
  always_comb begin
    mux_data = in_data[DATA_W-1:0];
    sel_oob  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        mux_data = in_data[k*DATA_W +: DATA_W];
        sel_oob  = 1'b0;
      end
    end
  end

  assign capture = !flush && !stall;

  // Next output state: flush clears, stall holds data/valid, otherwise capture.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sel_err_d   = 1'b0;
    if (flush) begin
      out_data_d  = '0;
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_data_d  = mux_data;
      out_valid_d = in_valid;
      sel_err_d   = sel_oob & in_valid;
    end
  end

  // Output register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

`ifdef FWD_MUX_STATS_EN
  logic [15:0] fwd_cnt_q, fwd_cnt_d;

  // Count valid captures that forward from a non-zero select.
  // Out-of-range selects are included, and the count saturates at all ones.
  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    if (capture && in_valid && (sel != '0) && (fwd_cnt_q != 16'hFFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 16'd1;
    end
  end

  // Statistics counter register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fwd_cnt_q <= 16'h0000;
    end else begin
      fwd_cnt_q <= fwd_cnt_d;
    end
  end

  assign fwd_cnt = fwd_cnt_q;
`else
  assign fwd_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_mux_reg.sv
// tb_fwd_mux_reg: bench for fwd_mux_reg.
// Two instances share the control signals:
//   - dut  uses NUM_IN=4 (power of two) and DATA_W=64.
//   - dut3 uses NUM_IN=3 and DATA_W=16, which allows an out-of-range select.
// A behavioural model tracks what each output register should hold.
// Honors FWD_MUX_STATS_EN for the expected fwd_cnt.
module tb_fwd_mux_reg;
  localparam int DW  = 64;
  localparam int NI  = 4;
  localparam int DW3 = 16;
  localparam int NI3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NI*DW-1:0]   in_data;
  logic [1:0]         sel;
  logic [NI3*DW3-1:0] in_data3;
  logic [1:0]         sel3;
  logic               in_valid, stall, flush;
  logic [DW-1:0]      out_data;
  logic               out_valid, sel_err;
  logic [15:0]        fwd_cnt;
  logic [DW3-1:0]     out_data3;
  logic               out_valid3, sel_err3;
  logic [15:0]        fwd_cnt3;

  fwd_mux_reg #(.DATA_W(DW), .NUM_IN(NI)) dut (
    .clk(clk), .arst_n(arst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .sel_err(sel_err),
    .fwd_cnt(fwd_cnt)
  );

  fwd_mux_reg #(.DATA_W(DW3), .NUM_IN(NI3)) dut3 (
    .clk(clk), .arst_n(arst_n), .in_data(in_data3), .sel(sel3),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_data(out_data3), .out_valid(out_valid3), .sel_err(sel_err3),
    .fwd_cnt(fwd_cnt3)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0]  ch  [NI];
  logic [DW3-1:0] ch3 [NI3];
  logic [DW-1:0]  m_data;
  logic           m_valid, m_err;
  logic [15:0]    m_cnt;
  logic [DW3-1:0] m_data3;
  logic           m_valid3, m_err3;
  logic [15:0]    m_cnt3;
  logic [DW-1:0]  exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : m_data;
    check({tag, ".data"},   64'(out_data),   64'(e));
    check({tag, ".valid"},  64'(out_valid),  64'(m_valid));
    check({tag, ".err"},    64'(sel_err),    64'(m_err));
    check({tag, ".cnt"},    64'(fwd_cnt),    64'(m_cnt));
    check({tag, ".data3"},  64'(out_data3),  64'(m_data3));
    check({tag, ".valid3"}, 64'(out_valid3), 64'(m_valid3));
    check({tag, ".err3"},   64'(sel_err3),   64'(m_err3));
    check({tag, ".cnt3"},   64'(fwd_cnt3),   64'(m_cnt3));
  endtask

  // ---------------- driver tasks ----------------
  task automatic pack_channels();
    for (int k = 0; k < NI; k++)  in_data[k*DW +: DW]    = ch[k];
    for (int k = 0; k < NI3; k++) in_data3[k*DW3 +: DW3] = ch3[k];
  endtask

  task automatic model_reset();
    m_data = '0; m_valid = 0; m_err = 0; m_cnt = 0;
    m_data3 = '0; m_valid3 = 0; m_err3 = 0; m_cnt3 = 0;
    exp_q.delete();
  endtask

  // Called at a negedge: drive the inputs, advance the model by one edge,
  // then check at the next negedge (when do_chk is set).
  task automatic apply(input int s, input int s3, input bit v, input bit st,
                       input bit fl, input bit do_chk, input string tag);
    int idx;
    sel = 2'(s); sel3 = 2'(s3); in_valid = v; stall = st; flush = fl;
    pack_channels();
    if (fl) begin
      m_data = '0; m_valid = 0; m_err = 0;
      m_data3 = '0; m_valid3 = 0; m_err3 = 0;
    end else if (st) begin
      m_err = 0; m_err3 = 0;
    end else begin
      m_data  = ch[s];
      m_valid = v;
      m_err   = 0;
      idx = (s3 < NI3) ? s3 : 0;
      m_data3  = ch3[idx];
      m_valid3 = v;
      m_err3   = v && (s3 >= NI3);
`ifdef FWD_MUX_STATS_EN
      if (v && s  != 0 && m_cnt  != 16'hFFFF) m_cnt  = m_cnt  + 1;
      if (v && s3 != 0 && m_cnt3 != 16'hFFFF) m_cnt3 = m_cnt3 + 1;
`endif
    end
    if (do_chk) exp_q.push_back(m_data);
    @(negedge clk);
    if (do_chk) check_all(tag);
  endtask

  task automatic do_reset();
    arst_n = 0; sel = 0; sel3 = 0; in_valid = 0; stall = 0; flush = 0;
    pack_channels();
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    arst_n = 1;
  endtask

  task automatic set_scenario_channels();
    for (int k = 0; k < NI; k++)  ch[k]  = DW'((k + 1) * 16);
    for (int k = 0; k < NI3; k++) ch3[k] = DW3'(16'h0A00 + (k + 1) * 16);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < NI; k++)  ch[k]  = '0;
    for (int k = 0; k < NI3; k++) ch3[k] = '0;
    in_data = '0; in_data3 = '0;
    @(negedge clk);
    do_reset();

    // Scenario 1: sel=2 -> 0x30 one clock later.
    set_scenario_channels();
    apply(2, 2, 1, 0, 0, 1, "s1");
    check("s1.data_const", 64'(out_data), 64'h30);

    // Scenario 2: sel 0..3 on consecutive cycles.
    do_reset();
    for (int i = 0; i < 4; i++) apply(i, i % 3, 1, 0, 0, 1, "s2");
`ifdef FWD_MUX_STATS_EN
    check("s2.cnt3_const", 64'(fwd_cnt), 64'd3);
`endif

    // Scenario 3: 0x20 registered, then a 3-cycle stall while sel changes.
    apply(1, 1, 1, 0, 0, 1, "s3.cap");
    for (int i = 0; i < 3; i++) apply(3 - i, i, 1, 1, 0, 1, "s3.stall");
    apply(3, 2, 1, 0, 0, 1, "s3.resume");

    // Scenario 4: flush together with stall, then keep stalling.
    apply(2, 0, 1, 1, 1, 1, "s4.flush");
    for (int i = 0; i < 3; i++) apply(i, 1, 1, 1, 0, 1, "s4.hold");
    apply(2, 2, 1, 0, 0, 1, "s4.resume");

    // Scenario 5: out-of-range select on the 3-input instance.
    apply(0, 3, 1, 0, 0, 1, "s5.oob");
    apply(0, 3, 0, 0, 0, 1, "s5.oob_novalid");
    apply(0, 3, 1, 0, 0, 1, "s5.oob2");
    apply(0, 1, 1, 0, 0, 1, "s5.pulse_end");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NI; k++)  ch[k]  = {$urandom, $urandom};
      for (int k = 0; k < NI3; k++) ch3[k] = DW3'($urandom);
      apply($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 1, "rand");
    end

    // Reset asserted mid-stall: outputs clear without waiting for an edge.
    set_scenario_channels();
    apply(1, 2, 1, 0, 0, 1, "mid.cap");
    apply(2, 1, 1, 1, 0, 1, "mid.stall");
    #2 arst_n = 0;
    #1;
    check("async.data",  64'(out_data),   64'h0);
    check("async.valid", 64'(out_valid),  64'h0);
    check("async.data3", 64'(out_data3),  64'h0);
    check("async.cnt",   64'(fwd_cnt),    64'h0);
    model_reset();
    @(negedge clk);
    arst_n = 1;
    apply(3, 1, 1, 1, 0, 1, "post.stall");
    apply(3, 1, 1, 0, 0, 1, "post.first_cap");

`ifdef FWD_MUX_STATS_EN
    // Saturation: bring the counter to 0xFFFE, then three more captures.
    do_reset();
    for (int i = 0; i < 65534; i++) apply(1, 2, 1, 0, 0, 0, "");
    check_all("sat.fffe");
    check("sat.fffe_const", 64'(fwd_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) apply(2, 1, 1, 0, 0, 1, "sat");
    check("sat.ffff_const", 64'(fwd_cnt), 64'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
